// File: rtl/dcache_wb_buffer_pkg.sv
// Shared memory-side types and the victim buffer entry layout.
package dcache_wb_buffer_pkg;

  localparam int DCACHE_WB_DEPTH = 4;

  typedef logic [31:0] ADDR;
  typedef logic [63:0] MEM_BLOCK;
  typedef logic [3:0]  MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef struct packed {
    logic [28:0] block_addr;
    MEM_BLOCK    data;
    logic        valid;
  } DCACHE_WB_ENTRY;

endpackage

// File: rtl/dcache_wb_buffer_if.sv
// Eviction, lookup and Dmem-side signals of the victim writeback buffer.
interface dcache_wb_buffer_if;
  import dcache_wb_buffer_pkg::*;

  logic       evict_valid;
  ADDR        evict_addr;
  MEM_BLOCK   evict_data;
  logic       evict_accept;
  ADDR        lookup_addr;
  logic       lookup_hit;
  MEM_BLOCK   lookup_data;
  logic       mem_grant;
  MEM_TAG     Dmem2proc_transaction_tag;
  MEM_COMMAND proc2Dmem_command;
  ADDR        proc2Dmem_addr;
  MEM_BLOCK   proc2Dmem_data;
  logic       wb_request;
  logic       empty;

  modport master (
    output evict_valid, evict_addr, evict_data, lookup_addr, mem_grant,
           Dmem2proc_transaction_tag,
    input  evict_accept, lookup_hit, lookup_data, proc2Dmem_command,
           proc2Dmem_addr, proc2Dmem_data, wb_request, empty
  );

  modport slave (
    input  evict_valid, evict_addr, evict_data, lookup_addr, mem_grant,
           Dmem2proc_transaction_tag,
    output evict_accept, lookup_hit, lookup_data, proc2Dmem_command,
           proc2Dmem_addr, proc2Dmem_data, wb_request, empty
  );
endinterface

// File: rtl/dcache_wb_buffer.sv
// Victim writeback FIFO: coalesces repeat evictions, serves dmshr lookups, drains as MEM_STORE.
module dcache_wb_buffer
  import dcache_wb_buffer_pkg::*;
#(
  parameter int DEPTH     = DCACHE_WB_DEPTH,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input logic              clock,
  input logic              reset,
  dcache_wb_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  DCACHE_WB_ENTRY       entries [DEPTH];
  logic [PW-1:0]        head, tail;
  logic [CNT_WIDTH-1:0] count;

  logic                 issuing, pop, push, coal, coal_found, not_full;
  logic [DEPTH-1:0]     ev_match, lk_match;
  logic [PW-1:0]        coal_idx, lk_idx;
  logic                 lk_found;
  logic                 unused_low_bits;

  function automatic logic [DEPTH-1:0] block_match(input logic [28:0] blk);
    logic [DEPTH-1:0] m;
    m = '0;
    for (int i = 0; i < DEPTH; i++)
      m[i] = entries[i].valid && (entries[i].block_addr == blk);
    return m;
  endfunction

  // Valid entries sit contiguously from head, so scanning from head leaves the youngest hit.
  function automatic logic [PW:0] youngest(input logic [DEPTH-1:0] m, input logic [PW-1:0] h);
    logic          found;
    logic [PW-1:0] idx, p;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      p = h + PW'(k);
      if (m[p]) begin
        found = 1'b1;
        idx   = p;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    issuing  = (count != '0) && bus.mem_grant;
    pop      = issuing && (bus.Dmem2proc_transaction_tag != '0);
    not_full = count < CNT_WIDTH'(DEPTH);
    ev_match = block_match(bus.evict_addr[31:3]);
    // A head leaving this cycle must not absorb new data; the victim gets its own slot.
    if (issuing) ev_match[head] = 1'b0;
    {coal_found, coal_idx} = youngest(ev_match, head);
    coal     = bus.evict_valid && coal_found;
    push     = bus.evict_valid && !coal_found && not_full;
    lk_match = block_match(bus.lookup_addr[31:3]);
    {lk_found, lk_idx} = youngest(lk_match, head);
  end

  assign bus.evict_accept      = not_full || coal_found;
  assign bus.lookup_hit        = lk_found;
  assign bus.lookup_data       = lk_found ? entries[lk_idx].data : '0;
  assign bus.proc2Dmem_command = issuing ? MEM_STORE : MEM_NONE;
  assign bus.proc2Dmem_addr    = issuing ? {entries[head].block_addr, 3'b000} : '0;
  assign bus.proc2Dmem_data    = issuing ? entries[head].data : '0;
  assign bus.wb_request        = (count != '0);
  assign bus.empty             = (count == '0);
  assign unused_low_bits       = ^{bus.evict_addr[2:0], bus.lookup_addr[2:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + PW'(1);
      end
      if (coal) entries[coal_idx].data <= bus.evict_data;
      if (push) begin
        entries[tail] <= '{block_addr: bus.evict_addr[31:3], data: bus.evict_data, valid: 1'b1};
        tail          <= tail + PW'(1);
      end
      count <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end
  end

endmodule
